loba_seq_mul_ctrl: RTL and testbench



---
 rtl/loba_seq_mul_ctrl.sv | 143 ++++++++++++++
 tb/tb_loba_seq_mul_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/loba_seq_mul_ctrl.sv
// loba_seq_mul_ctrl: sequential LOBA approximate 16x16 multiplier controller sharing one
// leading-one split unit and one 4x4 multiplier across up to four partial products.
module loba_seq_mul_ctrl #(
    parameter bit SKIP_ZERO   = 1'b1,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic [2:0]  pp_count,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, SPLIT_A, SPLIT_B, PP, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [3:0]  ah_q, ah_d, al_q, al_d, bh_q, bh_d, bl_q, bl_d;
    logic [3:0]  kha_q, kha_d, kla_q, kla_d, khb_q, khb_d, klb_q, klb_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] sx, lower;
    logic [3:0]  kh, kl, lo_pos, xh, xl;
    logic [1:0]  idx;
    logic [3:0]  xs, ys, kx, ky, mask_nx;
    logic [7:0]  prod;
    logic [4:0]  sh;
    logic [31:0] term;
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign p         = acc_q;
    assign pp_count  = cnt_q;
    always_comb begin
        sx = (state_q == SPLIT_A) ? a_q : b_q;
        kh = 4'd3;
        for (int i = 4; i < 16; i++) if (sx[i]) kh = 4'(i);
        lower = (kh >= 4'd7) ? (sx & ((16'd1 << (kh - 4'd3)) - 16'd1)) : 16'd0;
        lo_pos = 4'd0;
        for (int i = 0; i < 16; i++) if (lower[i]) lo_pos = 4'(i);
        kl = (lo_pos >= 4'd3) ? lo_pos : 4'd0;
        xh = 4'(sx >> (kh - 4'd3));
        xl = (kl != 4'd0) ? 4'(sx >> (kl - 4'd3)) : 4'd0;
    end
    // Lowest remaining mask bit picks the pair: bit1 of idx selects A's segment, bit0 B's.
    always_comb begin
        idx     = mask_q[0] ? 2'd0 : mask_q[1] ? 2'd1 : mask_q[2] ? 2'd2 : 2'd3;
        xs      = idx[1] ? al_q : ah_q;
        kx      = idx[1] ? kla_q : kha_q;
        ys      = idx[0] ? bl_q : bh_q;
        ky      = idx[0] ? klb_q : khb_q;
        prod    = {4'd0, xs} * {4'd0, ys};
        sh      = {1'b0, kx} + {1'b0, ky};
        term    = (xs == 4'd0 || ys == 4'd0) ? 32'd0 : ({24'd0, prod} << (sh - 5'd6));
        mask_nx = mask_q & (mask_q - 4'd1);
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ah_d    = ah_q;
        al_d    = al_q;
        bh_d    = bh_q;
        bl_d    = bl_q;
        kha_d   = kha_q;
        kla_d   = kla_q;
        khb_d   = khb_q;
        klb_d   = klb_q;
        mask_d  = mask_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                acc_d   = 32'd0;
                cnt_d   = 3'd0;
                state_d = (ZERO_BYPASS && (a == 16'd0 || b == 16'd0)) ? DONE : SPLIT_A;
            end
            SPLIT_A: begin
                ah_d    = xh;
                al_d    = xl;
                kha_d   = kh;
                kla_d   = kl;
                state_d = SPLIT_B;
            end
            SPLIT_B: begin
                bh_d    = xh;
                bl_d    = xl;
                khb_d   = kh;
                klb_d   = kl;
                mask_d  = SKIP_ZERO ? {al_q != 4'd0 && xl != 4'd0, al_q != 4'd0, xl != 4'd0, 1'b1} : 4'hF;
                state_d = PP;
            end
            PP: begin
                acc_d   = acc_q + term;
                cnt_d   = cnt_q + 3'd1;
                mask_d  = mask_nx;
                state_d = (mask_nx == 4'd0) ? DONE : PP;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ah_q    <= '0;
            al_q    <= '0;
            bh_q    <= '0;
            bl_q    <= '0;
            kha_q   <= '0;
            kla_q   <= '0;
            khb_q   <= '0;
            klb_q   <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ah_q    <= ah_d;
            al_q    <= al_d;
            bh_q    <= bh_d;
            bl_q    <= bl_d;
            kha_q   <= kha_d;
            kla_q   <= kla_d;
            khb_q   <= khb_d;
            klb_q   <= klb_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_loba_seq_mul_ctrl.sv
// tb_loba_seq_mul_ctrl: directed checks of the default build (skip/bypass on) alongside
// a build with both SKIP_ZERO and ZERO_BYPASS off, driven from the same operand stream.
module tb_loba_seq_mul_ctrl;
    logic        clk, rst, in_valid, out_ready;
    logic [15:0] a, b;
    logic        in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
    logic [31:0] p0, p1;
    logic [2:0]  pp0, pp1;
    int          errors = 0;
    int          checks = 0;

    loba_seq_mul_ctrl dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
        .out_valid(out_valid0), .out_ready(out_ready), .p(p0), .pp_count(pp0), .busy(busy0)
    );
    loba_seq_mul_ctrl #(.SKIP_ZERO(1'b0), .ZERO_BYPASS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
        .out_valid(out_valid1), .out_ready(out_ready), .p(p1), .pp_count(pp1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Latency is counted in rising edges after the accept edge until out_valid is seen.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] ep0, input int en0, input int el0,
                         input logic [31:0] ep1, input int en1, input int el1);
        int l0, l1;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        chk("in_ready0_pre", 32'(in_ready0), 32'd1);
        chk("in_ready1_pre", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        l0 = -1;
        l1 = -1;
        for (int k = 0; k < 20 && (l0 < 0 || l1 < 0); k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (l0 < 0 && out_valid0) l0 = k;
            if (l1 < 0 && out_valid1) l1 = k;
        end
        chk("lat0", 32'(l0), 32'(el0));
        chk("p0", p0, ep0);
        chk("pp0", 32'(pp0), 32'(en0));
        chk("lat1", 32'(l1), 32'(el1));
        chk("p1", p1, ep1);
        chk("pp1", 32'(pp1), 32'(en1));
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready0_post", 32'(in_ready0), 32'd1);
        chk("in_ready1_post", 32'(in_ready1), 32'd1);
        chk("busy0_post", 32'(busy0), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 16'd0;
        b = 16'd0;
        #1;
        chk("rst_in_ready", 32'(in_ready0), 32'd0);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_p", p0, 32'd0);
        chk("rst_pp", 32'(pp0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h00FF, 16'h0003, 32'd765, 2, 4, 32'd765, 4, 6);
        release_out();
        do_op(16'hFFFF, 16'hFFFF, 32'hFE010000, 4, 6, 32'hFE010000, 4, 6);
        release_out();
        do_op(16'h0000, 16'h1234, 32'd0, 0, 0, 32'd0, 4, 6);
        release_out();
        do_op(16'h0003, 16'h0003, 32'd9, 1, 3, 32'd9, 4, 6);
        release_out();

        // Stall the sink while new operands are offered; both builds sit in DONE.
        do_op(16'h00FF, 16'h0003, 32'd765, 2, 4, 32'd765, 4, 6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'h1111;
            b = 16'h2222;
            @(posedge clk);
            #1;
            chk("hold_p0", p0, 32'd765);
            chk("hold_ov0", 32'(out_valid0), 32'd1);
            chk("hold_rdy0", 32'(in_ready0), 32'd0);
            chk("hold_pp0", 32'(pp0), 32'd2);
            chk("hold_p1", p1, 32'd765);
        end
        release_out();
        do_op(16'h1111, 16'h2222, 32'd37879808, 4, 6, 32'd37879808, 4, 6);
        release_out();

        // Asynchronous reset while the first product of 0xFFFF*0xFFFF is accumulated.
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_pp0", 32'(pp0), 32'd1);
        chk("mid_p0", p0, 32'hE1000000);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid0), 32'd0);
        chk("arst_p", p0, 32'd0);
        chk("arst_pp", 32'(pp0), 32'd0);
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_in_ready", 32'(in_ready0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h00FF, 16'h0003, 32'd765, 2, 4, 32'd765, 4, 6);
        release_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
